// File: rtl/loop_filter_kcounter.sv
// loop_filter_kcounter: modulo-K up/down counter loop filter for the DPLL.
// Integrates the synchronised phase-detector error and emits one-cycle
// carry (advance) and borrow (retard) pulses when the count wraps.
// Optional lock detector enabled by defining LOOP_FILTER_LOCK_DETECT_EN.
module loop_filter_kcounter #(
    parameter int CNT_WIDTH         = 8,
    parameter int SYNC_STAGES       = 2,
    parameter int LOCK_WINDOW_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 errSig,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] modK,
    output logic                 carry,
    output logic                 borrow,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 locked
);

    localparam logic [CNT_WIDTH-1:0] RstCount = CNT_WIDTH'(1) << (CNT_WIDTH - 2);
    localparam logic [CNT_WIDTH-1:0] RstK     = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] MinK     = CNT_WIDTH'(2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_errSync;
    logic [CNT_WIDTH-1:0]   r_kReg;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_carry;
    logic                   r_borrow;
    logic [CNT_WIDTH-1:0]   w_effK;

    assign w_errSync = r_sync[SYNC_STAGES-1];
    assign w_effK    = (modK < MinK) ? MinK : modK;

    // Synchronise the asynchronous phase-detector output into the clk domain.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], errSig};
        end
    end

    // K counter: reload midscale while disabled, count up/down with wrap pulses while enabled.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_kReg   <= RstK;
            r_count  <= RstCount;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            if (!enable) begin
                r_kReg  <= w_effK;
                r_count <= w_effK >> 1;
            end else if (w_errSync) begin
                if (r_count == r_kReg - 1'b1) begin
                    r_count <= '0;
                    r_carry <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    r_count  <= r_kReg - 1'b1;
                    r_borrow <= 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign count  = r_count;
    assign carry  = r_carry;
    assign borrow = r_borrow;

`ifdef LOOP_FILTER_LOCK_DETECT_EN
    logic [LOCK_WINDOW_WIDTH-1:0] r_lockCnt;
    logic [LOCK_WINDOW_WIDTH-1:0] w_lockNext;
    logic                         r_locked;

    // Quiet-cycle counter: clears on a correction pulse or disable, otherwise saturates upward.
    always_comb begin
        w_lockNext = r_lockCnt;
        if (!enable || r_carry || r_borrow) begin
            w_lockNext = '0;
        end else if (r_lockCnt != '1) begin
            w_lockNext = r_lockCnt + 1'b1;
        end
    end

    // Register the quiet count and flag lock while it sits at full scale.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_lockCnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_lockCnt <= w_lockNext;
            r_locked  <= (w_lockNext == '1);
        end
    end

    assign locked = r_locked;
`else
    // Constant low for any legal window width; no lock logic is built.
    assign locked = (LOCK_WINDOW_WIDTH == 0);
`endif

endmodule
